// File: rtl/reg_file_multi.sv
// Multi-read-port register file with x0 hardwired to zero, a mirrored a0 output
// and a one-register-per-cycle clear sweep. Define REGFILE_BYPASS_EN for write-first reads.
module reg_file_multi #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int A0_IDX     = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADD_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    input  logic                           wr_en,
    input  logic [ADD_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [DATA_WIDTH-1:0]          a0
);

    localparam int                   DEPTH     = 2**ADD_WIDTH;
    localparam logic [ADD_WIDTH-1:0] PTR_START = ADD_WIDTH'(1);
    localparam logic [ADD_WIDTH-1:0] PTR_LAST  = ADD_WIDTH'(DEPTH - 1);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e                 state_q, state_d;
    logic [ADD_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_data_q [NUM_RD];
    logic [DATA_WIDTH-1:0]  rd_data_d [NUM_RD];
    logic                   wr_accept;

    // Writes are only honoured in IDLE; a write during a sweep is lost, not deferred.
    assign wr_accept = (state_q == IDLE) && wr_en && (wr_addr != '0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_accept) mem_d[wr_addr] = wr_data;
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = PTR_START;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = PTR_START;
                end else begin
                    ptr_d = ptr_q + ADD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr[k*ADD_WIDTH +: ADD_WIDTH] == '0)
                rd_data_d[k] = '0;
            else if (BYPASS && wr_accept && (wr_addr == rd_addr[k*ADD_WIDTH +: ADD_WIDTH]))
                rd_data_d[k] = wr_data;
            else
                rd_data_d[k] = mem_q[rd_addr[k*ADD_WIDTH +: ADD_WIDTH]];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_START;
            // NOTE: storage is reset here because a cleared file after reset is architectural, not a convenience.
            mem_q     <= '{default: '0};
            rd_data_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_pack
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
    end

    assign clr_busy = (state_q == CLEAR);
    assign a0       = mem_q[A0_IDX];

endmodule

// File: doc/reg_file_multi.md
REG_FILE_MULTI -- requirements
Module: reg_file_multi

Interface
REQ-001 Parameter ADD_WIDTH, default 5, SHALL set address width; depth = 2**ADD_WIDTH registers.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set register width.
REQ-003 Parameter NUM_RD, default 2, range 1..4, SHALL set the number of read ports.
REQ-004 Parameter A0_IDX, default 10, SHALL select the register mirrored on a0.
REQ-005 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 rd_addr  input  NUM_RD*ADD_WIDTH  SHALL carry the packed read addresses; port k uses slice [k*ADD_WIDTH +: ADD_WIDTH].
REQ-008 rd_data  output  NUM_RD*DATA_WIDTH  SHALL carry the packed registered read data, with the same slicing.
REQ-009 wr_en  input  1  SHALL be the write enable.
REQ-010 wr_addr  input  ADD_WIDTH  SHALL be the write address.
REQ-011 wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-012 clr_req  input  1  SHALL request a sequential clear of all registers.
REQ-013 clr_busy  output  1  SHALL be high while a clear sweep is in progress.
REQ-014 a0  output  DATA_WIDTH  SHALL present the storage contents of register A0_IDX, driven combinationally from storage.

Function
REQ-015 Each read port SHALL register its result: rd_data for port k in cycle n+1 reflects rd_addr port k sampled at edge n (1-cycle latency), on every non-reset cycle with no read enable.
REQ-016 Address 0 SHALL read as 0 on every port and SHALL ignore writes.
REQ-017 A write with wr_en=1, wr_addr!=0 and the FSM in IDLE SHALL update storage at the clock edge.
REQ-018 The FSM SHALL have two states: IDLE and CLEAR.
REQ-019 IDLE->CLEAR SHALL occur when clr_req=1 in IDLE; clr_busy SHALL be high from the following cycle.
REQ-020 In CLEAR, an internal pointer starting at 1 SHALL zero one register per cycle, in ascending order.
REQ-021 CLEAR->IDLE SHALL occur on the cycle that zeroes register 2**ADD_WIDTH-1; clr_busy SHALL be low the cycle after, so the sweep lasts 2**ADD_WIDTH-1 cycles.
REQ-022 wr_en SHALL be ignored while in CLEAR, and the write SHALL be dropped, not queued.
REQ-023 clr_req asserted while in CLEAR SHALL be ignored; it SHALL not restart the pointer.
REQ-024 Reads during CLEAR SHALL return current storage: registers already swept read 0, and unswept registers read their old value.
REQ-025 In IDLE, if wr_en=1 and clr_req=1 occur in the same cycle, the write SHALL complete first and the sweep SHALL then clear it.
REQ-026 Multiple read ports addressing the same register in the same cycle SHALL all return identical data.

Reset
REQ-027 When rst=1 at an edge, all registers SHALL become 0, rd_data SHALL become 0, the FSM SHALL enter IDLE, clr_busy SHALL become 0 and the pointer SHALL become 1.
REQ-028 Reset SHALL take priority over writes, clr_req and an in-progress sweep; a sweep interrupted by reset SHALL not resume.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, a read in the same cycle as an accepted write to the same nonzero address SHALL return wr_data in the next cycle (write-first).
REQ-030 Without REGFILE_BYPASS_EN, such a read SHALL return the value held before the write (read-first); a0 SHALL remain storage-driven in both builds.

Verification
REQ-031 Write 0xDEADBEEF to x5, then read x5 on port 0 one cycle later -> rd_data[0]=0xDEADBEEF in the following cycle.
REQ-032 Write 0x1234 to x0, then read x0 on all ports -> all rd_data slices = 0.
REQ-033 x7=0x11, then same-cycle write x7=0x22 and read x7 -> next cycle rd_data=0x22 with REGFILE_BYPASS_EN, 0x11 without.
REQ-034 Load x1..x31 nonzero, pulse clr_req -> clr_busy high for 31 cycles; a write to x3 mid-sweep is dropped; all registers read 0 after the sweep.
REQ-035 Write 0x55 to x10 -> a0=0x55 the cycle after the write edge.
REQ-036 Assert rst at cycle 10 of a sweep -> next cycle clr_busy=0, rd_data=0, a0=0; a write accepted in the next IDLE cycle succeeds.
